// File: rtl/decoder_proj_stream_if.sv
`default_nettype none
// ============================================================================
// Interface : decoder_proj_stream_if
// Brief     : Input and output valid/ready streams of decoder_proj_stream.
// Revision  : 1.0 - initial release
// ============================================================================
interface decoder_proj_stream_if #(
  parameter int SEL_W  = 3,
  parameter int PARITY = 1
);
  localparam int c_IN_W  = SEL_W + 1 + PARITY;
  localparam int c_OUT_W = 1 << SEL_W;

  logic                in_valid;
  logic                in_ready;
  logic [c_IN_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [c_OUT_W-1:0]  out_onehot;
  logic [SEL_W-1:0]    out_sel;
  logic                out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_onehot, out_sel, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_onehot, out_sel, out_err
  );
endinterface
`default_nettype wire

// File: rtl/decoder_proj_stream.sv
`default_nettype none
// ============================================================================
// Module   : decoder_proj_stream
// Brief    : FIFO-buffered, parity-checked select decoder with registered
//            one-hot output stage and saturating parity-error counter.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_proj_stream #(
  parameter int SEL_W  = 3,
  parameter int PARITY = 1,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  wire                  clock,
  input  wire                  reset_n,
  input  wire                  flush,
  decoder_proj_stream_if.slave bus,
  output logic [CNT_W-1:0]     err_count
);
  localparam int c_IN_W  = SEL_W + 1 + PARITY;
  localparam int c_OUT_W = 1 << SEL_W;
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL    = (c_PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [c_IN_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic               r_out_valid;
  logic [c_OUT_W-1:0] r_out_onehot;
  logic [SEL_W-1:0]   r_out_sel;
  logic               r_out_err;
  logic [CNT_W-1:0]   r_err_count;

  logic               w_in_ready;
  logic               w_push;
  logic               w_load;
  logic [c_IN_W-1:0]  w_head;
  logic               w_perr;
  logic               w_en;
  logic [SEL_W-1:0]   w_sel;
  logic [c_OUT_W-1:0] w_onehot;

  // in_ready comes from the registered count only, so no path from out_ready
  assign w_in_ready = (r_count != c_FULL);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_load     = (r_count != '0) && (!r_out_valid || bus.out_ready);

  assign w_head = r_mem[r_rd_ptr];
  assign w_en   = w_head[SEL_W];
  assign w_sel  = w_head[SEL_W-1:0];

  generate
    if (PARITY != 0) begin : g_parity
      assign w_perr = ^w_head;
    end else begin : g_no_parity
      assign w_perr = 1'b0;
    end
  endgenerate

  always_comb begin
    w_onehot = '0;
    if (w_en && !w_perr) begin
      w_onehot[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // err_count survives flush; a flushed cycle never loads, so it cannot count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_onehot <= '0;
      r_out_sel    <= '0;
      r_out_err    <= 1'b0;
      r_err_count  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_onehot <= w_onehot;
      r_out_sel    <= w_sel;
      r_out_err    <= w_perr;
      if (w_perr && (r_err_count != c_CNT_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_onehot = r_out_onehot;
  assign bus.out_sel    = r_out_sel;
  assign bus.out_err    = r_out_err;
  assign err_count      = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_decoder_proj_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_proj_stream
// Brief    : Directed and random checks of decoder_proj_stream against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_proj_stream;
  localparam int SEL_W  = 3;
  localparam int PARITY = 1;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush   = 1'b0;
  logic [CNT_W-1:0] err_count;

  decoder_proj_stream_if #(.SEL_W(SEL_W), .PARITY(PARITY)) bus ();

  decoder_proj_stream #(
    .SEL_W (SEL_W),
    .PARITY(PARITY),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .bus      (bus.slave),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  int         n_asserts = 0;
  int         n_fail    = 0;
  logic [4:0] m_q [$];
  bit         m_valid   = 1'b0;
  logic [4:0] m_word    = '0;
  int         m_cnt     = 0;

  function automatic bit m_perr(input logic [4:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  function automatic logic [7:0] m_onehot(input logic [4:0] w);
    logic [7:0] r;
    r = '0;
    if (w[3] && !m_perr(w)) r[w[2:0]] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(m_q.size() != DEPTH));
    chk({tag, ".err_count"}, 32'(err_count),     32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".onehot"}, 32'(bus.out_onehot), 32'(m_onehot(m_word)));
      chk({tag, ".sel"},    32'(bus.out_sel),    32'(m_word[2:0]));
      chk({tag, ".err"},    32'(bus.out_err),    32'(m_perr(m_word)));
    end
  endtask

  // Drive one cycle, advance the model across the edge, check just after it
  task automatic step(input string tag, input bit v, input logic [4:0] d,
                      input bit rdy, input bit fl);
    bit can_push;
    bit load;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clock);
    can_push = (m_q.size() != DEPTH);
    load     = (m_q.size() != 0) && (!m_valid || rdy);
    if (fl) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      if (load) begin
        m_word  = m_q.pop_front();
        m_valid = 1'b1;
        if (m_perr(m_word) && m_cnt < 255) m_cnt++;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (v && can_push) m_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    chk("rst.out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst.onehot",    32'(bus.out_onehot), 32'd0);
    chk("rst.sel",       32'(bus.out_sel),    32'd0);
    chk("rst.err",       32'(bus.out_err),    32'd0);
    chk("rst.err_count", 32'(err_count),      32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),   32'd1);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    step("basic_push", 1'b1, 5'b11101, 1'b1, 1'b0);
    chk("basic.latency", 32'(bus.out_valid), 32'd0);
    step("basic_out", 1'b0, 5'b00000, 1'b1, 1'b0);
    chk("basic.valid",  32'(bus.out_valid),  32'd1);
    chk("basic.onehot", 32'(bus.out_onehot), 32'h20);
    chk("basic.sel",    32'(bus.out_sel),    32'd5);
    chk("basic.err",    32'(bus.out_err),    32'd0);
    step("drain", 1'b0, 5'b00000, 1'b1, 1'b0);

    step("en0_push", 1'b1, 5'b00011, 1'b1, 1'b0);
    step("en0_out", 1'b0, 5'b00000, 1'b1, 1'b0);
    chk("en0.onehot",    32'(bus.out_onehot), 32'd0);
    chk("en0.err",       32'(bus.out_err),    32'd0);
    chk("en0.err_count", 32'(err_count),      32'd0);

    step("perr_push", 1'b1, 5'b01101, 1'b1, 1'b0);
    step("perr_out", 1'b0, 5'b00000, 1'b1, 1'b0);
    chk("perr.err",       32'(bus.out_err),    32'd1);
    chk("perr.onehot",    32'(bus.out_onehot), 32'd0);
    chk("perr.err_count", 32'(err_count),      32'd1);

    for (int i = 0; i < 300; i++) step("sat", 1'b1, 5'b01101, 1'b1, 1'b0);
    step("sat_drain", 1'b0, 5'b00000, 1'b1, 1'b0);
    step("sat_drain", 1'b0, 5'b00000, 1'b1, 1'b0);
    chk("sat.err_count", 32'(err_count), 32'd255);

    for (int i = 0; i < 6; i++) step("bp_fill", 1'b1, 5'(i * 7 + 3), 1'b0, 1'b0);
    chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
    chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 6; i++) step("bp_drain", 1'b0, 5'b00000, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) step("fl_fill", 1'b1, 5'(i * 5 + 9), 1'b0, 1'b0);
    step("flush", 1'b1, 5'b11101, 1'b0, 1'b1);
    chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush.in_ready",  32'(bus.in_ready),  32'd1);
    step("post_flush", 1'b0, 5'b00000, 1'b1, 1'b0);
    chk("post_flush.out_valid", 32'(bus.out_valid), 32'd0);

    // Async reset mid-stream, asserted and released between edges
    step("ar_fill", 1'b1, 5'b01101, 1'b0, 1'b0);
    step("ar_fill", 1'b1, 5'b11101, 1'b0, 1'b0);
    step("ar_fill", 1'b1, 5'b01010, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.err_count", 32'(err_count),     32'd0);
    chk("arst.in_ready",  32'(bus.in_ready),  32'd1);
    m_q.delete();
    m_valid = 1'b0;
    m_cnt   = 0;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
